// File: rtl/counter_dump_pkg.sv
// Shared types and constants for the counter dump transmitter.
package counter_dump_pkg;

   // Frame sequencer states; each non-idle state presents one kind of byte.
   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_ID,
      S_DATA,
      S_CSUM
   } state_t;

   // Default frame constants.
   localparam logic [7:0] HDR_DEF = 8'hA5;
   localparam logic [7:0] ID0_DEF = 8'h00;
   localparam logic [7:0] ID1_DEF = 8'h01;

   // Sel encodings (any value with bit 1 set means "both counters").
   localparam logic [1:0] SEL_C0   = 2'b00;
   localparam logic [1:0] SEL_C1   = 2'b01;
   localparam logic [1:0] SEL_BOTH = 2'b10;

   localparam int CNT_W_DEF = 64;

   // Bytes per frame: header, id, payload, checksum.
   function automatic int frame_len(input int cnt_w);
      return cnt_w / 8 + 3;
   endfunction

   localparam int FRAME_LEN = frame_len(CNT_W_DEF);

endpackage

// File: rtl/counter_dump_tx_if.sv
// 8-bit valid/ready byte stream between the dump transmitter and its sink.
interface counter_dump_tx_if;
   logic [7:0] Dout;
   logic       Dvalid;
   logic       Dready;

   modport master (output Dout, output Dvalid, input Dready);
   modport slave  (input Dout, input Dvalid, output Dready);
endinterface

// File: rtl/counter_dump_tx_byte_sel.sv
// Chooses the byte to present for a given frame position.
module dump_byte_sel
   import counter_dump_pkg::*;
#(
   parameter int         CNT_W = CNT_W_DEF,
   parameter logic [7:0] HDR   = HDR_DEF,
   parameter int         IW    = 3
) (
   input  state_t           state,
   input  logic [IW-1:0]    idx,
   input  logic [CNT_W-1:0] snap,
   input  logic [7:0]       id,
   input  logic [7:0]       csum,
   output logic [7:0]       nxt_byte
);

   localparam int NB = CNT_W / 8;

   // Byte view of the snapshot; index 0 is least significant.
   logic [NB-1:0][7:0] snap_b;
   logic [IW-1:0]      ridx;

   assign snap_b = snap;
   // Payload goes out MSB first, so byte index 0 maps to the top byte.
   assign ridx   = IW'(NB - 1) - idx;

   // Byte mux by frame position.
   always_comb begin
      nxt_byte = '0;
      case (state)
         S_HDR:   nxt_byte = HDR;
         S_ID:    nxt_byte = id;
         S_DATA:  nxt_byte = snap_b[ridx];
         S_CSUM:  nxt_byte = csum;
         default: nxt_byte = '0;
      endcase
   end

endmodule

// File: rtl/counter_dump_tx.sv
// Snapshots the dual event counter on request and streams each value as a
// framed packet: HDR, ID, payload (MSB first), XOR checksum.
module counter_dump_tx
   import counter_dump_pkg::*;
#(
   parameter int         CNT_W = CNT_W_DEF,
   parameter logic [7:0] HDR   = HDR_DEF,
   parameter logic [7:0] ID0   = ID0_DEF,
   parameter logic [7:0] ID1   = ID1_DEF
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [CNT_W-1:0] Cnt0,
   input  logic [CNT_W-1:0] Cnt1,
   input  logic             Req,
   input  logic [1:0]       Sel,
   counter_dump_tx_if.master strm,
   output logic             Busy,
   output logic             Done
);

   localparam int            NB   = CNT_W / 8;
   localparam int            IW   = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [IW-1:0] LAST = IW'(NB - 1);

   state_t           state_q, state_n;
   logic [IW-1:0]    idx_q, idx_n;
   logic [7:0]       csum_q, csum_n;
   logic             frm_q, frm_n;   // 0: counter-0 frame, 1: counter-1 frame
   logic             both_q;         // second frame pending after counter 0
   logic [CNT_W-1:0] snap0_q, snap1_q;
   logic             done_n;
   logic             hs;
   logic [CNT_W-1:0] snap_nxt;
   logic [7:0]       id_nxt;
   logic [7:0]       nxt_byte;

   assign hs = strm.Dvalid && strm.Dready;

   // Next-state, byte index and running checksum; everything holds without a handshake.
   always_comb begin
      state_n = state_q;
      idx_n   = idx_q;
      csum_n  = csum_q;
      frm_n   = frm_q;
      done_n  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Req) begin
               state_n = S_HDR;
               frm_n   = (Sel == SEL_C1);
               idx_n   = '0;
               csum_n  = '0;
            end
         end
         S_HDR: begin
            if (hs) begin
               csum_n  = csum_q ^ strm.Dout;
               state_n = S_ID;
            end
         end
         S_ID: begin
            if (hs) begin
               csum_n  = csum_q ^ strm.Dout;
               idx_n   = '0;
               state_n = S_DATA;
            end
         end
         S_DATA: begin
            if (hs) begin
               csum_n = csum_q ^ strm.Dout;
               if (idx_q == LAST) state_n = S_CSUM;
               else               idx_n   = idx_q + 1'b1;
            end
         end
         S_CSUM: begin
            if (hs) begin
               if (!frm_q && both_q) begin
                  // Chain straight into the counter-1 frame, no idle gap.
                  state_n = S_HDR;
                  frm_n   = 1'b1;
                  idx_n   = '0;
                  csum_n  = '0;
               end else begin
                  state_n = S_IDLE;
                  done_n  = 1'b1;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // The byte for the next cycle is built from next-state values so Dout is a register.
   assign snap_nxt = frm_n ? snap1_q : snap0_q;
   assign id_nxt   = frm_n ? ID1 : ID0;

   dump_byte_sel #(.CNT_W(CNT_W), .HDR(HDR), .IW(IW)) u_sel (
      .state    (state_n),
      .idx      (idx_n),
      .snap     (snap_nxt),
      .id       (id_nxt),
      .csum     (csum_n),
      .nxt_byte (nxt_byte)
   );

   // State, snapshot and registered output updates.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         csum_q      <= '0;
         frm_q       <= 1'b0;
         both_q      <= 1'b0;
         snap0_q     <= '0;
         snap1_q     <= '0;
         strm.Dout   <= '0;
         strm.Dvalid <= 1'b0;
         Busy        <= 1'b0;
         Done        <= 1'b0;
      end else begin
         state_q <= state_n;
         idx_q   <= idx_n;
         csum_q  <= csum_n;
         frm_q   <= frm_n;
         // Both counters captured on the same edge so the pair is coherent.
         if (state_q == S_IDLE && Req) begin
            snap0_q <= Cnt0;
            snap1_q <= Cnt1;
            both_q  <= Sel[1];
         end
         strm.Dout   <= (state_n == S_IDLE) ? 8'h00 : nxt_byte;
         strm.Dvalid <= (state_n != S_IDLE);
         Busy        <= (state_n != S_IDLE);
         Done        <= done_n;
      end
   end

endmodule

// File: tb/tb_counter_dump_tx.sv
// Directed bench for counter_dump_tx with a byte scoreboard.
module tb_counter_dump_tx;
   import counter_dump_pkg::*;

   logic        Clk   = 1'b0;
   logic        Reset = 1'b0;
   logic [63:0] Cnt0  = '0;
   logic [63:0] Cnt1  = '0;
   logic        Req   = 1'b0;
   logic [1:0]  Sel   = 2'b00;
   logic        Busy;
   logic        Done;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  q[$];

   counter_dump_tx_if strm();

   counter_dump_tx dut (
      .Clk   (Clk),
      .Reset (Reset),
      .Cnt0  (Cnt0),
      .Cnt1  (Cnt1),
      .Req   (Req),
      .Sel   (Sel),
      .strm  (strm),
      .Busy  (Busy),
      .Done  (Done)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected frame: A5, id, value MSB first, XOR of all of those.
   task automatic push_frame(input logic [7:0] id, input logic [63:0] v);
      logic [7:0] c;
      logic [7:0] b;
      c = 8'hA5 ^ id;
      q.push_back(8'hA5);
      q.push_back(id);
      for (int i = 7; i >= 0; i--) begin
         b = v[8*i +: 8];
         q.push_back(b);
         c = c ^ b;
      end
      q.push_back(c);
   endtask

   // Scoreboard: every accepted byte is compared with the head of the queue.
   always @(negedge Clk) begin
      if (Reset === 1'b1 && strm.Dvalid === 1'b1 && strm.Dready === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL extra_byte: got %0h expected no byte", strm.Dout);
         end else begin
            chk("byte", {56'h0, strm.Dout}, {56'h0, q.pop_front()});
         end
      end
   end

   // One request, run to Done; optional stall window and ignored mid-frame Req.
   task automatic xfer(input logic [1:0] sel, input int stall_at, input int stall_len,
                       input int req_at, input int exp_done, input bit incr, input bit post);
      int n;
      bit got;
      @(posedge Clk); #1;
      if (sel[1]) begin
         push_frame(8'h00, Cnt0);
         push_frame(8'h01, Cnt1);
      end else if (sel == SEL_C1) push_frame(8'h01, Cnt1);
      else push_frame(8'h00, Cnt0);
      Sel = sel;
      Req = 1'b1;
      @(posedge Clk); #1;
      Req = 1'b0;
      n = 0;
      got = 1'b0;
      while (n < 100 && !got) begin
         n++;
         strm.Dready = !(stall_len > 0 && n >= stall_at && n < stall_at + stall_len);
         Req = (n == req_at);
         if (incr) begin
            Cnt0 = Cnt0 + 1;
            Cnt1 = Cnt1 + 1;
         end
         @(negedge Clk);
         if (n == 1) begin
            chk("first_valid", {63'h0, strm.Dvalid}, 64'h1);
            chk("first_hdr", {56'h0, strm.Dout}, 64'hA5);
            chk("first_busy", {63'h0, Busy}, 64'h1);
         end
         if (stall_len > 0 && n >= stall_at && n < stall_at + stall_len) begin
            chk("stall_valid", {63'h0, strm.Dvalid}, 64'h1);
            chk("stall_dout", {56'h0, strm.Dout}, 64'h00);
         end
         if (Done === 1'b1) got = 1'b1;
         else begin
            @(posedge Clk); #1;
         end
      end
      Req = 1'b0;
      strm.Dready = 1'b1;
      chk("done_cycle", 64'(n), 64'(exp_done));
      chk("queue_empty", 64'(q.size()), 64'h0);
      if (post) begin
         @(posedge Clk); #1;
         @(negedge Clk);
         chk("done_one_cycle", {63'h0, Done}, 64'h0);
         chk("idle_busy", {63'h0, Busy}, 64'h0);
         chk("idle_valid", {63'h0, strm.Dvalid}, 64'h0);
      end
   endtask

   initial begin
      int n;
      strm.Dready = 1'b1;
      #1;
      chk("rst_valid", {63'h0, strm.Dvalid}, 64'h0);
      chk("rst_busy", {63'h0, Busy}, 64'h0);
      chk("rst_done", {63'h0, Done}, 64'h0);
      chk("rst_dout", {56'h0, strm.Dout}, 64'h0);
      #20 Reset = 1'b1;
      repeat (2) @(negedge Clk);
      chk("idle_after_rst", {63'h0, strm.Dvalid}, 64'h0);

      // Counter 0 only.
      Cnt0 = 64'h5;
      xfer(SEL_C0, 0, 0, 0, FRAME_LEN + 1, 1'b0, 1'b1);

      // Counter 1 only.
      Cnt1 = 64'h0123_4567_89AB_CDEF;
      xfer(SEL_C1, 0, 0, 0, FRAME_LEN + 1, 1'b0, 1'b1);

      // Both, counters moving after the request.
      Cnt0 = 64'h5;
      Cnt1 = 64'h0123_4567_89AB_CDEF;
      xfer(SEL_BOTH, 0, 0, 0, 2 * FRAME_LEN + 1, 1'b1, 1'b1);

      // Three-cycle stall on byte 4.
      Cnt0 = 64'h5;
      xfer(SEL_C0, 4, 3, 0, FRAME_LEN + 4, 1'b0, 1'b1);

      // Req during byte 6 is ignored; Req in the Done cycle starts a new frame.
      Cnt0 = 64'hDEAD_BEEF_0000_1234;
      xfer(SEL_C0, 0, 0, 6, FRAME_LEN + 1, 1'b0, 1'b0);
      push_frame(8'h00, Cnt0);
      Sel = SEL_C0;
      Req = 1'b1;
      @(posedge Clk); #1;
      Req = 1'b0;
      @(negedge Clk);
      chk("done_req_valid", {63'h0, strm.Dvalid}, 64'h1);
      chk("done_req_hdr", {56'h0, strm.Dout}, 64'hA5);
      n = 1;
      while (n < 100 && Done !== 1'b1) begin
         @(negedge Clk);
         n++;
      end
      chk("done_req_cycle", 64'(n), 64'(FRAME_LEN + 1));
      chk("done_req_queue", 64'(q.size()), 64'h0);

      // Asynchronous reset mid-payload.
      @(posedge Clk); #1;
      Cnt0 = 64'h1111_2222_3333_4444;
      push_frame(8'h00, Cnt0);
      Sel = SEL_C0;
      Req = 1'b1;
      @(posedge Clk); #1;
      Req = 1'b0;
      repeat (4) @(posedge Clk);
      #3 Reset = 1'b0;
      #1;
      chk("arst_valid", {63'h0, strm.Dvalid}, 64'h0);
      chk("arst_busy", {63'h0, Busy}, 64'h0);
      chk("arst_dout", {56'h0, strm.Dout}, 64'h0);
      q.delete();
      @(negedge Clk); #2 Reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         chk("post_arst_idle", {62'h0, strm.Dvalid, Busy}, 64'h0);
      end

      // Recovery after reset.
      Cnt1 = 64'h0000_0000_0000_00FF;
      xfer(SEL_C1, 0, 0, 0, FRAME_LEN + 1, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/counter_dump_tx.md
Name: counter_dump_tx

Overview:
- Downstream consumer of the dual 64-bit event counter (the block driven by Clk/Reset/Slt/En that exposes Output0/Output1).
- On request, takes a coherent snapshot of one or both counter values and serializes each as an 11-byte framed packet on an 8-bit valid/ready byte stream.
- Feeds the debug UART/host link.
- Read-only: never drives the counter's inputs.

Parameters:
- CNT_W, 64, width of each counter input; must be a multiple of 8.
- HDR, 8'hA5, frame header byte.
- ID0, 8'h00, ID byte for counter 0 frames.
- ID1, 8'h01, ID byte for counter 1 frames.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset (Reset=0 resets).
- Cnt0  in  CNT_W  counter 0 value (from Output0).
- Cnt1  in  CNT_W  counter 1 value (from Output1).
- Req  in  1  dump request; sampled only in IDLE.
- Sel  in  2  00 = counter 0; 01 = counter 1; 1x = both (counter 0 frame, then counter 1 frame).
- Dout  out  8  stream byte.
- Dvalid  out  1  Dout valid.
- Dready  in  1  sink accepts the byte when Dvalid&&Dready at a rising edge.
- Busy  out  1  transfer in progress.
- Done  out  1  one-cycle pulse at end of transfer.

Behaviour:
- Reset (asynchronous, immediate):
  - Dout=0, Dvalid=0, Busy=0, Done=0.
  - State=IDLE; snapshots, byte index and checksum cleared.
  - Reset mid-frame aborts the frame with no further bytes; Dvalid drops without waiting for a clock.
- States: IDLE, HDR, ID, DATA, CSUM.
- IDLE, Req=1 at edge:
  - Capture Cnt0 and Cnt1 into snapshot registers in the same edge (coherent pair).
  - Latch Sel.
  - Go to HDR.
  - Busy=1 and Dvalid=1 with Dout=HDR from the next cycle (latency 1).
- Transitions:
  - Each state advances only on handshake: HDR -> ID -> DATA -> CSUM.
  - DATA emits CNT_W/8 bytes, most significant byte first; the byte index advances per accepted byte.
- Frame content:
  - HDR, ID, data bytes, CSUM.
  - ID is ID0 or ID1.
  - CSUM is the XOR of HDR, ID and all data bytes.
  - Frame length is 11 bytes for CNT_W=64.
- Sel=1x:
  - After the counter-0 CSUM is accepted, go directly to HDR of the counter-1 frame with no idle cycle.
  - Both frames use the snapshot taken at request time.
- Backpressure:
  - While Dvalid=1 and Dready=0, Dout and Dvalid are held stable.
  - Dvalid never deasserts until the byte is accepted.
- Throughput: with Dready held at 1, one byte per cycle (11 cycles per frame, 22 for both).
- End of transfer:
  - On acceptance of the last CSUM, go to IDLE.
  - Next cycle: Busy=0, Dvalid=0, Done=1 for exactly one cycle.
  - A Req in that Done cycle is accepted normally.
- Req while Busy=1 is ignored (not queued).
- Changes on Cnt0/Cnt1 after capture have no effect on the frame in flight.
- Checksum register:
  - Cleared at HDR entry.
  - Updated combinationally with each emitted byte so CSUM is valid when the CSUM state is entered.
- All outputs are registered; no combinational path from Dready to Dvalid or Dout.

Decomposition:
- Shared package counter_dump_pkg:
  - state enum (IDLE, HDR, ID, DATA, CSUM).
  - HDR, ID0, ID1 constants.
  - Sel encodings.
  - Frame length constant.
- One sub-module: dump_byte_sel (combinational).
  - Inputs: state, byte index, active snapshot, ID, checksum.
  - Output: the next byte value.
  - Keeps the top level as FSM plus registers.

Test Plan:
1. Reset=0 then 1; Cnt0=64'h5; pulse Req with Sel=00; Dready=1.
   -> Dvalid from the cycle after Req; bytes A5 00 00 00 00 00 00 00 00 05 A0 on 11 consecutive cycles; then Busy=0 and a single-cycle Done.
2. Cnt1=64'h0123_4567_89AB_CDEF, Sel=01, Dready=1.
   -> A5 01 01 23 45 67 89 AB CD EF A4.
3. Sel=10, Cnt0=64'h5, Cnt1 as in test 2; increment both counters every cycle after Req.
   -> 22 back-to-back bytes: the test 1 frame, then the test 2 frame, both using request-time values; Done once at the end.
4. Scenario 1 with Dready=0 for 3 cycles while byte 4 is presented.
   -> Dout=00 and Dvalid=1 stable for those 3 cycles; the stream resumes with no byte lost or duplicated; Done is 3 cycles later than in test 1.
5. Pulse Req again during byte 6 of a frame.
   -> Ignored; exactly one frame emitted.
   -> A Req in the Done cycle starts a new frame (Dvalid=1 with A5 the next cycle).
6. Assert Reset=0 asynchronously between edges mid-DATA.
   -> Dvalid, Busy and Dout go to 0 immediately; after release, the block sits idle until the next Req.
